sigmoid_share_arb: RTL

- Shares one pipelined piecewise-linear sigmoid evaluator between NREQ requesters.
- Arbitration is round-robin over per-requester valid/ready input channels.
- Each accepted operand is tagged with its requester index and returned on a single valid/ready result channel.
- Sits between the neuron-accumulator lanes and the activation writeback; numbers are Q4.16 fixed point, where 65536 = 1.0.

---
 rtl/sigmoid_share_arb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sigmoid_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : sigmoid_share_arb
// Description : Round-robin shared 2-stage piecewise-linear sigmoid (Q4.16).
// Revision    : 1.0
// ============================================================================
module sigmoid_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [20*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [19:0]       res_data,
    output logic [IDW-1:0]    res_id
);

    localparam logic [19:0] c_one    = 20'd65536;
    localparam logic [19:0] c_sat    = 20'd327680;
    localparam logic [19:0] c_knee2  = 20'd155648;
    localparam logic [19:0] c_knee1  = 20'd65536;

    logic            r_s1_valid;
    logic [19:0]     r_s1_x;
    logic [IDW-1:0]  r_s1_id;
    logic            r_s2_valid;
    logic [19:0]     r_res_data;
    logic [IDW-1:0]  r_res_id;
    logic [IDW-1:0]  r_ptr;

    logic            w_adv;
    logic            w_can_load;
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic [IDW:0]    w_sum;
    logic            w_fire;
    logic [19:0]     w_sel_data;
    logic [19:0]     w_m;
    logic [19:0]     w_f;
    logic [19:0]     w_res;

    assign w_adv      = !r_s2_valid || res_ready;
    assign w_can_load = !r_s1_valid || w_adv;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IDW-1:0];
            end
        end
    end

    assign w_fire     = w_found && w_can_load && !rst;
    assign req_ready  = w_fire ? (NREQ'(1) << w_win) : '0;
    assign w_sel_data = req_data[int'(w_win)*20 +: 20];

    assign w_m = r_s1_x[19] ? (~r_s1_x + 20'd1) : r_s1_x;

    always_comb begin
        w_f = c_one;
        if (w_m >= c_sat) begin
            w_f = c_one;
        end else if (w_m >= c_knee2) begin
            w_f = (w_m >> 5) + 20'd55296;
        end else if (w_m >= c_knee1) begin
            w_f = (w_m >> 3) + 20'd40960;
        end else begin
            w_f = (w_m >> 2) + 20'd32768;
        end
    end

    // Odd symmetry: sigmoid(-x) = 1 - sigmoid(x).
    assign w_res = r_s1_x[19] ? (c_one - w_f) : w_f;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
            r_s1_id    <= '0;
            r_s2_valid <= 1'b0;
            r_res_data <= '0;
            r_res_id   <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_res_data <= w_res;
                    r_res_id   <= r_s1_id;
                end
            end
            if (w_can_load) begin
                r_s1_valid <= w_fire;
                if (w_fire) begin
                    r_s1_x  <= w_sel_data;
                    r_s1_id <= w_win;
                end
            end
            if (w_fire) begin
                r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;

endmodule
`default_nettype wire
